// File: rtl/phase_sequencer.sv
// Run/step/load control sequencer for a small stored-program machine.
// Moore FSM: HALT -> (LOAD | FETCH -> EXEC) with a completed-instruction counter.
module phase_sequencer (
  input  logic        clk,
  input  logic        resetBar,
  input  logic        run,
  input  logic        step,
  input  logic [7:0]  ir,
  input  logic        ldReq,
  output logic [1:0]  phase,
  output logic        fetchEn,
  output logic        execEn,
  output logic        loaderSel,
  output logic        loaderWrite,
  output logic        ldAck,
  output logic        halted,
  output logic [15:0] instrCount
);

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    LOAD  = 2'd3
  } phaseT;

  phaseT       stateReg, stateNext;
  logic        stepPrevReg;
  logic        stepPendingReg, stepPendingNext;
  logic        haltedReg, haltedNext;
  logic [15:0] instrCountReg;
  logic        stepEdge;
  logic        isHaltInstr;
  logic        enterFetch;

  assign stepEdge    = step & ~stepPrevReg;
  // HALT reuses the otherwise unused destination code 3'b111.
  assign isHaltInstr = (ir[3:1] == 3'b111);

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      HALT: begin
        if (ldReq)
          stateNext = LOAD;
        else if (run || stepPendingReg)
          stateNext = FETCH;
      end
      FETCH: stateNext = EXEC;
      EXEC: begin
        if (isHaltInstr)
          stateNext = HALT;
        else if (run)
          stateNext = FETCH;
        else
          stateNext = HALT;
      end
      LOAD:    stateNext = HALT;
      default: stateNext = HALT;
    endcase
  end

  assign enterFetch = (stateNext == FETCH);

  // A fresh edge wins over the clear so a press coinciding with a fetch is not lost.
  always_comb begin
    stepPendingNext = stepPendingReg;
    if (stepEdge)
      stepPendingNext = 1'b1;
    else if (enterFetch)
      stepPendingNext = 1'b0;
  end

  always_comb begin
    haltedNext = haltedReg;
    if (stateReg == EXEC && isHaltInstr)
      haltedNext = 1'b1;
    else if (stateReg == HALT && stateNext == FETCH)
      haltedNext = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetBar) begin
      stateReg       <= HALT;
      stepPrevReg    <= step;
      stepPendingReg <= 1'b0;
      haltedReg      <= 1'b0;
      instrCountReg  <= 16'd0;
    end else begin
      stateReg       <= stateNext;
      stepPrevReg    <= step;
      stepPendingReg <= stepPendingNext;
      haltedReg      <= haltedNext;
      if (stateReg == EXEC)
        instrCountReg <= instrCountReg + 16'd1;
    end
  end

  assign phase       = stateReg;
  assign fetchEn     = (stateReg == FETCH);
  assign execEn      = (stateReg == EXEC);
  assign loaderSel   = (stateReg == LOAD);
  assign loaderWrite = (stateReg == LOAD);
  assign ldAck       = (stateReg == LOAD);
  assign halted      = haltedReg;
  assign instrCount  = instrCountReg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: expected strobe events go into a queue
// and a forked monitor pops/compares them whenever the DUT raises a strobe.
module tb_phase_sequencer;

  logic        clk;
  logic        resetBar;
  logic        run;
  logic        step;
  logic [7:0]  ir;
  logic        ldReq;
  logic [1:0]  phase;
  logic        fetchEn;
  logic        execEn;
  logic        loaderSel;
  logic        loaderWrite;
  logic        ldAck;
  logic        halted;
  logic [15:0] instrCount;

  phase_sequencer dut (
    .clk         (clk),
    .resetBar    (resetBar),
    .run         (run),
    .step        (step),
    .ir          (ir),
    .ldReq       (ldReq),
    .phase       (phase),
    .fetchEn     (fetchEn),
    .execEn      (execEn),
    .loaderSel   (loaderSel),
    .loaderWrite (loaderWrite),
    .ldAck       (ldAck),
    .halted      (halted),
    .instrCount  (instrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ph;
    logic [15:0] cnt;
    logic        hlt;
  } evT;

  evT          sbQ[$];
  evT          monEv;
  int          tests;
  int          fails;
  logic [15:0] expCount;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] strobeFor(input logic [1:0] ph);
    case (ph)
      2'd1:    return 5'b10000;
      2'd2:    return 5'b01000;
      2'd3:    return 5'b00111;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pushEv(input logic [1:0] ph, input logic [15:0] cnt, input logic hlt);
    evT e;
    e.ph  = ph;
    e.cnt = cnt;
    e.hlt = hlt;
    sbQ.push_back(e);
  endtask

  task automatic pushInstr;
    pushEv(2'd1, expCount, 1'b0);
    pushEv(2'd2, expCount, 1'b0);
    expCount = expCount + 16'd1;
  endtask

  task automatic checkIdle(input string name);
    check({name, "_phase"}, {30'd0, phase}, 32'd0);
    check({name, "_strobes"}, {27'd0, fetchEn, execEn, loaderSel, loaderWrite, ldAck}, 32'd0);
  endtask

  task automatic checkPhase(input string name, input logic [1:0] exp);
    check(name, {30'd0, phase}, {30'd0, exp});
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    expCount = 16'd0;
    resetBar = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    ir       = 8'h00;
    ldReq    = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (fetchEn || execEn || loaderSel || loaderWrite || ldAck) begin
          if (sbQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: phase=%0d strobes=%05b with no expected event", phase,
                     {fetchEn, execEn, loaderSel, loaderWrite, ldAck});
          end else begin
            monEv = sbQ.pop_front();
            $display("[TB] event phase=%0d count=%04h halted=%0d (expected phase=%0d count=%04h halted=%0d)",
                     phase, instrCount, halted, monEv.ph, monEv.cnt, monEv.hlt);
            check("sb_phase", {30'd0, phase}, {30'd0, monEv.ph});
            check("sb_strobes", {27'd0, fetchEn, execEn, loaderSel, loaderWrite, ldAck},
                  {27'd0, strobeFor(monEv.ph)});
            check("sb_count", {16'd0, instrCount}, {16'd0, monEv.cnt});
            check("sb_halted", {31'd0, halted}, {31'd0, monEv.hlt});
          end
        end
      end
    join_none

    // Reset state
    tick;
    tick;
    checkIdle("rst");
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_count", {16'd0, instrCount}, 32'd0);

    // Free run: three back-to-back instructions with no idle cycles
    resetBar = 1'b1;
    run      = 1'b1;
    ir       = 8'h04;
    pushInstr;
    pushInstr;
    pushInstr;
    for (int i = 0; i < 6; i++) begin
      tick;
      checkPhase("run3_phase", (i % 2 == 0) ? 2'd1 : 2'd2);
      if (i == 5) run = 1'b0;
    end
    tick;
    checkIdle("run3_end");
    check("run3_count", {16'd0, instrCount}, 32'd3);

    // Single step with the button held: exactly one instruction
    step = 1'b1;
    pushInstr;
    repeat (10) tick;
    checkIdle("step_held");
    check("step_count", {16'd0, instrCount}, 32'd4);
    step = 1'b0;
    tick;
    tick;

    // Step edge during EXEC is remembered and runs a second instruction
    step = 1'b1;
    pushInstr;
    pushInstr;
    tick;
    checkPhase("step2_wait", 2'd0);
    step = 1'b0;
    tick;
    checkPhase("step2_f1", 2'd1);
    tick;
    checkPhase("step2_e1", 2'd2);
    step = 1'b1;
    tick;
    checkPhase("step2_h", 2'd0);
    step = 1'b0;
    tick;
    checkPhase("step2_f2", 2'd1);
    tick;
    tick;
    checkIdle("step2_end");
    check("step2_count", {16'd0, instrCount}, 32'd6);

    // HALT instruction stops even with run held high
    run = 1'b1;
    ir  = 8'h0E;
    pushEv(2'd1, 16'd6, 1'b0);
    pushEv(2'd2, 16'd6, 1'b0);
    expCount = 16'd7;
    tick;
    tick;
    checkPhase("hlt_exec", 2'd2);
    tick;
    checkIdle("hlt_stop");
    check("hlt_flag", {31'd0, halted}, 32'd1);
    check("hlt_count", {16'd0, instrCount}, 32'd7);

    // ldReq and run together in HALT: LOAD first, halted survives LOAD
    ldReq = 1'b1;
    ir    = 8'h04;
    pushEv(2'd3, 16'd7, 1'b1);
    pushInstr;
    tick;
    checkPhase("ld_first", 2'd3);
    check("ld_ack", {31'd0, ldAck}, 32'd1);
    check("ld_halted", {31'd0, halted}, 32'd1);
    ldReq = 1'b0;
    tick;
    checkPhase("ld_back", 2'd0);
    check("ld_halted2", {31'd0, halted}, 32'd1);
    tick;
    checkPhase("ld_fetch", 2'd1);
    check("ld_haltclr", {31'd0, halted}, 32'd0);
    tick;
    run = 1'b0;
    tick;
    checkIdle("ld_end");
    check("ld_count", {16'd0, instrCount}, 32'd8);

    // ldReq raised during FETCH waits for HALT without aborting the instruction
    run = 1'b1;
    pushInstr;
    pushEv(2'd3, 16'd9, 1'b0);
    tick;
    checkPhase("ldw_fetch", 2'd1);
    ldReq = 1'b1;
    run   = 1'b0;
    tick;
    checkPhase("ldw_exec", 2'd2);
    tick;
    checkPhase("ldw_halt", 2'd0);
    tick;
    checkPhase("ldw_load", 2'd3);
    ldReq = 1'b0;
    tick;
    checkIdle("ldw_end");
    check("ldw_count", {16'd0, instrCount}, 32'd9);

    // Step edge coinciding with a load survives the LOAD
    step  = 1'b1;
    ldReq = 1'b1;
    pushEv(2'd3, 16'd9, 1'b0);
    pushInstr;
    tick;
    checkPhase("sl_load", 2'd3);
    ldReq = 1'b0;
    step  = 1'b0;
    tick;
    checkPhase("sl_halt", 2'd0);
    tick;
    checkPhase("sl_fetch", 2'd1);
    tick;
    tick;
    checkIdle("sl_end");
    check("sl_count", {16'd0, instrCount}, 32'd10);

    // Reset with ldReq pending: no LOAD, counter cleared, no spurious step edge
    ldReq    = 1'b1;
    step     = 1'b1;
    resetBar = 1'b0;
    tick;
    checkIdle("rld");
    check("rld_count", {16'd0, instrCount}, 32'd0);
    expCount = 16'd0;
    resetBar = 1'b1;
    pushEv(2'd3, 16'd0, 1'b0);
    tick;
    checkPhase("rld_load", 2'd3);
    ldReq = 1'b0;
    tick;
    tick;
    tick;
    checkIdle("rld_nostep");
    step = 1'b0;

    // Reset during EXEC aborts without counting
    run = 1'b1;
    pushEv(2'd1, 16'd0, 1'b0);
    pushEv(2'd2, 16'd0, 1'b0);
    tick;
    tick;
    checkPhase("rex_exec", 2'd2);
    resetBar = 1'b0;
    tick;
    checkIdle("rex");
    check("rex_count", {16'd0, instrCount}, 32'd0);
    resetBar = 1'b1;
    run      = 1'b0;
    tick;
    checkIdle("rex_after");

    // Counter wrap: preload near the top, then run two instructions
    force dut.instrCountReg = 16'hFFFE;
    #1;
    release dut.instrCountReg;
    check("wrap_preset", {16'd0, instrCount}, 32'h0000FFFE);
    expCount = 16'hFFFE;
    run = 1'b1;
    pushInstr;
    pushInstr;
    tick;
    tick;
    tick;
    check("wrap_ffff", {16'd0, instrCount}, 32'h0000FFFF);
    tick;
    run = 1'b0;
    tick;
    checkIdle("wrap_end");
    check("wrap_zero", {16'd0, instrCount}, {16'd0, expCount});

    tick;
    tick;
    check("sb_drained", sbQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
